// File: rtl/branch_update_queue.sv
// In-order queue of predicted conditional branches, from allocation at fetch to resolution at execute.
// Latency: a resolve drives update_en/mispredict/resolve_err on the following clock edge.
// Backpressure: alloc_ready drops when the queue is full, with no same-cycle resolve bypass.
module branch_update_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic              alloc_pred,
    output logic              alloc_ready,
    output logic [ADDR_W-1:0] alloc_tag,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    input  logic              flush,
    output logic              update_en,
    output logic [PC_W-1:0]   update_pc,
    output logic              outcome,
    output logic              mispredict,
    output logic              resolve_err,
    output logic [ADDR_W:0]   count,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
    } entry_t;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    entry_t            mem [DEPTH];
    entry_t            rd_entry;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic              alloc_fire;
    logic              res_fire;
    logic              mis_fire;
    logic              clear;

    assign alloc_ready = (count != FULL);
    assign alloc_tag   = wr_ptr;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign res_fire    = resolve_valid & (count != '0);
    assign rd_entry    = mem[rd_ptr];
    assign mis_fire    = res_fire & (rd_entry.pred != resolve_taken);
    // A mispredict makes every younger entry wrong-path, same effect as a flush.
    assign clear       = flush | mis_fire;
    assign rd_ptr_nxt  = res_fire ? rd_ptr + ADDR_W'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (alloc_fire && !clear) begin
            mem[wr_ptr] <= '{pc: alloc_pc, pred: alloc_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            update_en   <= 1'b0;
            update_pc   <= '0;
            outcome     <= 1'b0;
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (clear) begin
                wr_ptr <= rd_ptr_nxt;
                count  <= '0;
            end else begin
                if (alloc_fire) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                count <= count + (ADDR_W+1)'(alloc_fire) - (ADDR_W+1)'(res_fire);
            end

            update_en   <= res_fire;
            mispredict  <= mis_fire;
            resolve_err <= resolve_valid & (count == '0);
            if (res_fire) begin
                update_pc <= rd_entry.pc;
                outcome   <= resolve_taken;
            end

            if (res_fire && branch_cnt != '1) begin
                branch_cnt <= branch_cnt + STAT_W'(1);
            end
            if (mis_fire && mispred_cnt != '1) begin
                mispred_cnt <= mispred_cnt + STAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: default instance plus a narrow-statistics instance.
module tb_branch_update_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [31:0] alloc_pc = '0;
    logic        alloc_pred = 1'b0;
    logic        resolve_valid = 1'b0;
    logic        resolve_taken = 1'b0;
    logic        flush = 1'b0;

    logic        alloc_ready, update_en, outcome, mispredict, resolve_err;
    logic [2:0]  alloc_tag;
    logic [31:0] update_pc;
    logic [3:0]  count;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        s_alloc_ready, s_update_en, s_outcome, s_mispredict, s_resolve_err;
    logic [2:0]  s_alloc_tag;
    logic [31:0] s_update_pc;
    logic [3:0]  s_count;
    logic [3:0]  s_branch_cnt, s_mispred_cnt;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    branch_update_queue dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .update_en(update_en), .update_pc(update_pc), .outcome(outcome),
        .mispredict(mispredict), .resolve_err(resolve_err), .count(count),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_update_queue #(.STAT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(s_alloc_ready), .alloc_tag(s_alloc_tag),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .update_en(s_update_en), .update_pc(s_update_pc), .outcome(s_outcome),
        .mispredict(s_mispredict), .resolve_err(s_resolve_err), .count(s_count),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pred);
        alloc_valid = 1'b1;
        alloc_pc    = pc;
        alloc_pred  = pred;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic taken);
        resolve_valid = 1'b1;
        resolve_taken = taken;
        tick();
        resolve_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_count", count, 4'd0);
        chk("rst_update_en", update_en, 1'b0);
        chk("rst_update_pc", update_pc, 32'h0);
        chk("rst_branch_cnt", branch_cnt, 16'd0);
        chk("rst_alloc_ready", alloc_ready, 1'b1);
        chk("rst_alloc_tag", alloc_tag, 3'd0);
        reset = 1'b1;

        // Basic in-order training
        do_alloc(32'h100, 1'b1);
        do_alloc(32'h104, 1'b0);
        do_alloc(32'h108, 1'b1);
        chk("basic_count3", count, 4'd3);
        do_resolve(1'b1);
        chk("basic_upd0", update_en, 1'b1);
        chk("basic_pc0", update_pc, 32'h100);
        chk("basic_out0", outcome, 1'b1);
        chk("basic_mis0", mispredict, 1'b0);
        do_resolve(1'b0);
        chk("basic_upd1", update_en, 1'b1);
        chk("basic_pc1", update_pc, 32'h104);
        chk("basic_out1", outcome, 1'b0);
        chk("basic_mis1", mispredict, 1'b0);
        do_resolve(1'b1);
        chk("basic_pc2", update_pc, 32'h108);
        chk("basic_mis2", mispredict, 1'b0);
        chk("basic_count0", count, 4'd0);
        tick();
        chk("basic_upd_drop", update_en, 1'b0);
        chk("basic_branch_cnt", branch_cnt, 16'd3);
        chk("basic_mispred_cnt", mispred_cnt, 16'd0);

        // Fill to full, refuse extra allocs, then stream with pointer wrap
        for (int i = 0; i < 8; i++) begin
            do_alloc(32'h200 + 32'(4 * i), 1'b0);
            exp_q.push_back(32'h200 + 32'(4 * i));
        end
        chk("full_count", count, 4'd8);
        chk("full_ready", alloc_ready, 1'b0);
        do_alloc(32'h300, 1'b0);
        chk("full_9th_count", count, 4'd8);
        alloc_valid = 1'b1; alloc_pc = 32'h3fc; alloc_pred = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        exp_pc = exp_q.pop_front();
        chk("full_res_alloc_count", count, 4'd7);
        chk("full_res_pc", update_pc, exp_pc);
        chk("full_res_ready", alloc_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            alloc_pc = 32'h400 + 32'(4 * i);
            exp_q.push_back(alloc_pc);
            tick();
            exp_pc = exp_q.pop_front();
            chk("stream_pc", update_pc, exp_pc);
            chk("stream_upd", update_en, 1'b1);
        end
        alloc_valid = 1'b0;
        chk("stream_count", count, 4'd7);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            chk("drain_pc", update_pc, exp_pc);
        end
        resolve_valid = 1'b0;
        chk("drain_count", count, 4'd0);
        chk("drain_branch_cnt", branch_cnt, 16'd31);
        chk("drain_tag", alloc_tag, 3'd7);

        // Mispredict recovery squashes younger entries and a same-cycle alloc
        do_alloc(32'h500, 1'b1);
        do_alloc(32'h504, 1'b0);
        do_alloc(32'h508, 1'b0);
        do_alloc(32'h50c, 1'b0);
        alloc_valid = 1'b1; alloc_pc = 32'h600; alloc_pred = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        tick();
        alloc_valid = 1'b0; resolve_valid = 1'b0;
        chk("mis_pulse", mispredict, 1'b1);
        chk("mis_upd", update_en, 1'b1);
        chk("mis_outcome", outcome, 1'b0);
        chk("mis_pc", update_pc, 32'h500);
        chk("mis_count", count, 4'd0);
        chk("mis_cnt", mispred_cnt, 16'd1);
        chk("mis_tag", alloc_tag, 3'd0);
        tick();
        chk("mis_pulse_drop", mispredict, 1'b0);
        do_alloc(32'h700, 1'b1);
        do_resolve(1'b1);
        chk("mis_after_pc", update_pc, 32'h700);
        chk("mis_after_mis", mispredict, 1'b0);
        chk("mis_after_branch", branch_cnt, 16'd33);

        // Resolve on empty queue
        do_resolve(1'b1);
        chk("empty_err", resolve_err, 1'b1);
        chk("empty_upd", update_en, 1'b0);
        chk("empty_branch", branch_cnt, 16'd33);
        tick();
        chk("empty_err_drop", resolve_err, 1'b0);

        // Flush with concurrent correct resolve and discarded alloc
        for (int i = 0; i < 5; i++) do_alloc(32'h800 + 32'(4 * i), 1'b1);
        chk("flush_pre_count", count, 4'd5);
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_pc = 32'h900; alloc_pred = 1'b1;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; resolve_valid = 1'b0;
        chk("flush_upd", update_en, 1'b1);
        chk("flush_pc", update_pc, 32'h800);
        chk("flush_mis", mispredict, 1'b0);
        chk("flush_count", count, 4'd0);
        do_resolve(1'b1);
        chk("flush_later_upd", update_en, 1'b0);
        chk("flush_later_err", resolve_err, 1'b1);
        chk("flush_branch", branch_cnt, 16'd34);

        // Saturating statistics on the narrow instance
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_alloc(32'ha00 + 32'(4 * i), 1'b1);
            do_resolve(1'b0);
        end
        chk("sat4_mispred", s_mispred_cnt, 4'd15);
        chk("sat4_branch", s_branch_cnt, 4'd15);
        chk("sat16_mispred", mispred_cnt, 16'd17);
        chk("sat16_branch", branch_cnt, 16'd17);

        // Reset mid-stream with resolve held high
        do_alloc(32'hb00, 1'b1);
        do_alloc(32'hb04, 1'b1);
        do_alloc(32'hb08, 1'b1);
        chk("mid_pre_count", count, 4'd3);
        reset = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b1;
        tick();
        chk("mid_count", count, 4'd0);
        chk("mid_upd", update_en, 1'b0);
        chk("mid_pc", update_pc, 32'h0);
        chk("mid_outcome", outcome, 1'b0);
        chk("mid_mis", mispredict, 1'b0);
        chk("mid_err", resolve_err, 1'b0);
        chk("mid_branch", branch_cnt, 16'd0);
        chk("mid_mispred", mispred_cnt, 16'd0);
        chk("mid_s_mispred", s_mispred_cnt, 4'd0);
        reset = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("post_rst_upd", update_en, 1'b0);
        chk("post_rst_err", resolve_err, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
